// File: rtl/fb_writer_if.sv
// fb_writer_if: command handshake and frame RAM write port of fb_writer.
interface fb_writer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [9:0]  cmd_x;
    logic [9:0]  cmd_y;
    logic [3:0]  cmd_color;
    logic [18:0] ram_addr;
    logic [3:0]  ram_data;
    logic        ram_we;
    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color,
        input  cmd_ready, ram_addr, ram_data, ram_we
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color,
        output cmd_ready, ram_addr, ram_data, ram_we
    );
endinterface

// File: rtl/fb_writer.sv
// fb_writer: framebuffer pixel writes and full-screen clears into a row-major frame RAM.
// Defining FB_VSYNC_GATE_EN holds each clear until the next lcd_vsync rising edge.
module fb_writer #(
    parameter int H_RES = 800,
    parameter int V_RES = 480
) (
    input  logic          pixel_clock,
    input  logic          pixel_reset,
    input  logic          lcd_vsync,
    fb_writer_if.slave    bus,
    output logic          busy,
    output logic          dropped
);
    typedef enum logic [1:0] {IDLE, WAIT_VS, CLEAR} state_t;
    localparam logic [9:0]  X_LIM = 10'(H_RES);
    localparam logic [9:0]  Y_LIM = 10'(V_RES);
    localparam logic [18:0] ROW   = 19'(H_RES);
    localparam logic [18:0] LAST  = 19'(H_RES * V_RES - 1);
    state_t      state, state_next;
    logic        ready_q, vs_q, accept, in_range, last;
    logic [3:0]  color;
    logic [18:0] pix_addr;
    assign bus.cmd_ready = ready_q && state == IDLE;
    assign busy = state != IDLE;
    always_comb begin
        accept = bus.cmd_valid && bus.cmd_ready;
        in_range = bus.cmd_x < X_LIM && bus.cmd_y < Y_LIM;
        pix_addr = 19'(bus.cmd_y) * ROW + 19'(bus.cmd_x);
        last = bus.ram_we && bus.ram_addr == LAST;
        state_next = state;
        case (state)
`ifdef FB_VSYNC_GATE_EN
            IDLE:    state_next = accept && bus.cmd_op ? WAIT_VS : IDLE;
`else
            IDLE:    state_next = accept && bus.cmd_op ? CLEAR : IDLE;
`endif
            WAIT_VS: state_next = lcd_vsync && !vs_q ? CLEAR : WAIT_VS;
            CLEAR:   state_next = last ? IDLE : CLEAR;
            default: state_next = IDLE;
        endcase
    end
    // ram_we low in CLEAR means the sweep has not started yet, so it begins at address 0
    always_ff @(posedge pixel_clock) begin
        if (!pixel_reset) begin
            state        <= IDLE;
            ready_q      <= 1'b0;
            vs_q         <= 1'b0;
            color        <= '0;
            dropped      <= 1'b0;
            bus.ram_we   <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_data <= '0;
        end else begin
            state      <= state_next;
            ready_q    <= 1'b1;
            vs_q       <= lcd_vsync;
            bus.ram_we <= 1'b0;
            dropped    <= accept && !bus.cmd_op && !in_range;
            if (accept && !bus.cmd_op && in_range) begin
                bus.ram_we   <= 1'b1;
                bus.ram_addr <= pix_addr;
                bus.ram_data <= bus.cmd_color;
            end
            if (accept && bus.cmd_op) begin
                color <= bus.cmd_color;
`ifndef FB_VSYNC_GATE_EN
                bus.ram_we   <= 1'b1;
                bus.ram_addr <= '0;
                bus.ram_data <= bus.cmd_color;
`endif
            end
            if (state == CLEAR && !last) begin
                bus.ram_we   <= 1'b1;
                bus.ram_addr <= bus.ram_we ? bus.ram_addr + 19'd1 : '0;
                bus.ram_data <= color;
            end
        end
    end
endmodule

// File: tb/tb_fb_writer.sv
// tb_fb_writer: directed vector table for pixel writes plus clear and reset-abort sequences.
module tb_fb_writer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_b, rst_s, vsync, busy_b, busy_s, drop_b, drop_s;
    fb_writer_if bb ();
    fb_writer_if sb ();
    fb_writer u_big (
        .pixel_clock(clk), .pixel_reset(rst_b), .lcd_vsync(vsync),
        .bus(bb.slave), .busy(busy_b), .dropped(drop_b)
    );
    fb_writer #(.H_RES(8), .V_RES(4)) u_small (
        .pixel_clock(clk), .pixel_reset(rst_s), .lcd_vsync(vsync),
        .bus(sb.slave), .busy(busy_s), .dropped(drop_s)
    );
    typedef struct {
        logic        valid;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [3:0]  c;
        logic        we;
        logic [18:0] addr;
        logic [3:0]  data;
        logic        drop;
    } vec_t;
    localparam int N = 12;
    vec_t vecs [N];
    int applied = 0;
    int miscompares = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // {we, addr, data, busy, ready} of the selected instance
    function automatic logic [25:0] obs(input bit s);
        return s ? {sb.ram_we, sb.ram_addr, sb.ram_data, busy_s, sb.cmd_ready}
                 : {bb.ram_we, bb.ram_addr, bb.ram_data, busy_b, bb.cmd_ready};
    endfunction
    task automatic drive(input bit s, input logic v, input logic op, input logic [9:0] x,
                         input logic [9:0] y, input logic [3:0] c);
        if (s) begin
            sb.cmd_valid = v; sb.cmd_op = op; sb.cmd_x = x; sb.cmd_y = y; sb.cmd_color = c;
        end else begin
            bb.cmd_valid = v; bb.cmd_op = op; bb.cmd_x = x; bb.cmd_y = y; bb.cmd_color = c;
        end
    endtask
    // Issues a clear and returns in the cycle where the write to address 0 must appear
    task automatic start_clear(input bit s, input logic [3:0] c, input string tag);
`ifdef FB_VSYNC_GATE_EN
        int w;
`endif
        drive(s, 1'b1, 1'b1, 10'd0, 10'd0, c);
        @(negedge clk);
        drive(s, 1'b0, 1'b0, 10'd0, 10'd0, 4'h0);
`ifdef FB_VSYNC_GATE_EN
        w = 0;
        for (int k = 0; k < 50; k++) begin
            if (obs(s)[25] || !obs(s)[1]) w++;
            @(negedge clk);
        end
        chk({tag, "_no_write_before_vsync"}, 64'(w), 64'd0);
        vsync = 1'b1;
        @(negedge clk);
        chk({tag, "_no_write_rise_cycle"}, 64'(obs(s)[25]), 64'd0);
        @(negedge clk);
        vsync = 1'b0;
`endif
    endtask
    initial begin
        int bad;
        vecs[0]  = '{1'b1, 10'd5,    10'd2,    4'hA, 1'b1, 19'd1605,   4'hA, 1'b0};
        vecs[1]  = '{1'b1, 10'd799,  10'd479,  4'h3, 1'b1, 19'd383999, 4'h3, 1'b0};
        vecs[2]  = '{1'b1, 10'd0,    10'd0,    4'h7, 1'b1, 19'd0,      4'h7, 1'b0};
        vecs[3]  = '{1'b1, 10'd800,  10'd0,    4'h5, 1'b0, 19'd0,      4'h7, 1'b1};
        vecs[4]  = '{1'b1, 10'd0,    10'd480,  4'h5, 1'b0, 19'd0,      4'h7, 1'b1};
        vecs[5]  = '{1'b0, 10'd1,    10'd1,    4'h1, 1'b0, 19'd0,      4'h7, 1'b0};
        vecs[6]  = '{1'b1, 10'd799,  10'd0,    4'hF, 1'b1, 19'd799,    4'hF, 1'b0};
        vecs[7]  = '{1'b1, 10'd0,    10'd1,    4'h2, 1'b1, 19'd800,    4'h2, 1'b0};
        vecs[8]  = '{1'b1, 10'd1023, 10'd1023, 4'h1, 1'b0, 19'd800,    4'h2, 1'b1};
        vecs[9]  = '{1'b1, 10'd10,   10'd100,  4'h9, 1'b1, 19'd80010,  4'h9, 1'b0};
        vecs[10] = '{1'b0, 10'd20,   10'd20,   4'h6, 1'b0, 19'd80010,  4'h9, 1'b0};
        vecs[11] = '{1'b1, 10'd123,  10'd456,  4'hC, 1'b1, 19'd364923, 4'hC, 1'b0};
        rst_b = 1'b0; rst_s = 1'b0; vsync = 1'b0;
        drive(0, 1'b0, 1'b0, 10'd0, 10'd0, 4'h0);
        drive(1, 1'b0, 1'b0, 10'd0, 10'd0, 4'h0);
        repeat (3) @(negedge clk);
        chk("reset_big", 64'({obs(0), drop_b}), 64'd0);
        chk("reset_small", 64'({obs(1), drop_s}), 64'd0);
        rst_b = 1'b1; rst_s = 1'b1;
        @(negedge clk);
        chk("ready_after_reset_big", 64'({bb.cmd_ready, busy_b}), 64'b10);
        chk("ready_after_reset_small", 64'({sb.cmd_ready, busy_s}), 64'b10);
        for (int i = 0; i <= N; i++) begin
            if (i > 0)
                chk($sformatf("pixel_vec%0d", i - 1),
                    64'({bb.ram_we, bb.ram_addr, bb.ram_data, drop_b, bb.cmd_ready, busy_b}),
                    64'({vecs[i-1].we, vecs[i-1].addr, vecs[i-1].data, vecs[i-1].drop, 1'b1, 1'b0}));
            if (i < N) drive(0, vecs[i].valid, 1'b0, vecs[i].x, vecs[i].y, vecs[i].c);
            else drive(0, 1'b0, 1'b0, 10'd0, 10'd0, 4'h0);
            @(negedge clk);
        end
        start_clear(1, 4'h4, "small");
        bad = 0;
        for (int e = 0; e < 32; e++) begin
            if (obs(1) !== {1'b1, 19'(e), 4'h4, 1'b1, 1'b0}) bad++;
            @(negedge clk);
        end
        chk("small_clear_sweep", 64'(bad), 64'd0);
        chk("small_clear_done", 64'(obs(1)), 64'({1'b0, 19'd31, 4'h4, 1'b0, 1'b1}));
        drive(1, 1'b1, 1'b0, 10'd3, 10'd2, 4'h9);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 10'd8, 10'd0, 4'h1);
        chk("small_pixel_after_clear", 64'({obs(1), drop_s}), 64'({1'b1, 19'd19, 4'h9, 1'b0, 1'b1, 1'b0}));
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 10'd0, 10'd0, 4'h0);
        chk("small_drop_x_eq_hres", 64'({obs(1), drop_s}), 64'({1'b0, 19'd19, 4'h9, 1'b0, 1'b1, 1'b1}));
        start_clear(0, 4'hB, "big");
        bad = 0;
        for (int e = 0; e <= 1000; e++) begin
            if (obs(0) !== {1'b1, 19'(e), 4'hB, 1'b1, 1'b0}) bad++;
            if (e < 1000) @(negedge clk);
        end
        chk("big_clear_sweep_to_1000", 64'(bad), 64'd0);
        rst_b = 1'b0;
        @(negedge clk);
        chk("big_reset_mid_clear", 64'({obs(0), drop_b}), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        chk("big_ready_after_abort", 64'({bb.cmd_ready, busy_b}), 64'b10);
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            if (bb.ram_we || busy_b) bad++;
            @(negedge clk);
        end
        chk("big_no_resume_after_abort", 64'(bad), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
